// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default widths for the memory bus arbiter.
// Used by the arbiter top and its round-robin grant helper.
package mem_bus_arbiter_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_TMR_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin grant between IFU and LSU.
// On contention the side that did not win last time is granted.
module mem_bus_arbiter_rr_arb2
    import mem_bus_arbiter_pkg::*;
(
    input  logic   i_en,
    input  logic   i_ifu_valid,
    input  logic   i_lsu_valid,
    input  owner_e i_last_grant,
    output logic   o_ifu_gnt,
    output logic   o_lsu_gnt
);

    assign o_lsu_gnt = i_en && i_lsu_valid && (!i_ifu_valid || (i_last_grant == OWN_IFU));
    assign o_ifu_gnt = i_en && i_ifu_valid && (!i_lsu_valid || (i_last_grant == OWN_LSU));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store with one
// transaction in flight, round-robin arbitration and a bounded response timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TMR_W   = DEF_TMR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_err
);

    localparam logic [TMR_W-1:0] TMO_LIMIT = TMR_W'(TIMEOUT);

    state_e                r_state;
    state_e                w_state_next;
    owner_e                r_owner;
    owner_e                r_last_grant;
    logic [TMR_W-1:0]      r_timer;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wmask;

    logic                  w_idle;
    logic                  w_busy;
    logic                  w_ifu_gnt;
    logic                  w_lsu_gnt;
    logic                  w_grant;
    logic                  w_rsp_fire;
    logic                  w_expire;
    logic                  w_rsp_valid;
    logic [DATA_W-1:0]     w_rsp_data;
    logic                  w_rsp_err;

    // Gating with rst_n keeps the ready outputs low while reset is held.
    assign w_idle  = (r_state == ST_IDLE) && rst_n;
    assign w_busy  = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign w_grant = w_ifu_gnt || w_lsu_gnt;

    mem_bus_arbiter_rr_arb2 u_rr_arb2 (
        .i_en         (w_idle),
        .i_ifu_valid  (ifu_req_valid),
        .i_lsu_valid  (lsu_req_valid),
        .i_last_grant (r_last_grant),
        .o_ifu_gnt    (w_ifu_gnt),
        .o_lsu_gnt    (w_lsu_gnt)
    );

    // A response arriving in the expiry cycle takes priority over the timeout.
    assign w_rsp_fire = (r_state == ST_WAIT) && mem_rsp_valid;
    assign w_expire   = (TIMEOUT != 0) && w_busy && (r_timer == TMO_LIMIT) && !w_rsp_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_grant) w_state_next = ST_REQ;
            ST_REQ: begin
                if (w_expire)           w_state_next = ST_IDLE;
                else if (mem_req_ready) w_state_next = ST_WAIT;
            end
            ST_WAIT: if (w_rsp_fire || w_expire) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_IFU;
            r_timer      <= '0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else if (w_grant) begin
            r_owner      <= w_lsu_gnt ? OWN_LSU : OWN_IFU;
            r_last_grant <= w_lsu_gnt ? OWN_LSU : OWN_IFU;
            r_timer      <= '0;
            r_addr       <= w_lsu_gnt ? lsu_addr : ifu_addr;
            r_wen        <= w_lsu_gnt && lsu_wen;
            r_wdata      <= w_lsu_gnt ? lsu_wdata : '0;
            r_wmask      <= (w_lsu_gnt && lsu_wen) ? lsu_wmask : '0;
        end else if (w_busy && (r_timer != '1)) begin
            r_timer      <= r_timer + 1'b1;
        end
    end

    assign mem_req_valid = (r_state == ST_REQ) && !w_expire;
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    // A timeout looks like an error response with zero data.
    assign w_rsp_valid = w_rsp_fire || w_expire;
    assign w_rsp_data  = w_rsp_fire ? mem_rsp_data : '0;
    assign w_rsp_err   = w_rsp_fire ? mem_rsp_err : 1'b1;

    assign ifu_req_ready = w_ifu_gnt;
    assign lsu_req_ready = w_lsu_gnt;

    assign ifu_rsp_valid = w_rsp_valid && (r_owner == OWN_IFU);
    assign ifu_rsp_data  = ifu_rsp_valid ? w_rsp_data : '0;
    assign ifu_rsp_err   = ifu_rsp_valid && w_rsp_err;

    assign lsu_rsp_valid = w_rsp_valid && (r_owner == OWN_LSU);
    assign lsu_rsp_data  = lsu_rsp_valid ? w_rsp_data : '0;
    assign lsu_rsp_err   = lsu_rsp_valid && w_rsp_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with TIMEOUT=4: expected responses are
// queued when the memory side is driven and matched when a response appears.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_rsp_data;
    logic        mem_req_valid, mem_req_ready, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_data;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .TMR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        check("ready_exclusive", 64'(ifu_req_ready & lsu_req_ready), 64'd0);
        if (!ifu_rsp_valid) check("ifu_rsp_quiet", {ifu_rsp_data, ifu_rsp_err}, 64'd0);
        if (!lsu_rsp_valid) check("lsu_rsp_quiet", {lsu_rsp_data, lsu_rsp_err}, 64'd0);
        if (ifu_rsp_valid || lsu_rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", {lsu_rsp_valid, ifu_rsp_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_route", {lsu_rsp_valid, ifu_rsp_valid}, e.port ? 64'd2 : 64'd1);
                if (e.port) begin
                    if (e.chk) check("lsu_rsp_data", lsu_rsp_data, e.data);
                    check("lsu_rsp_err", lsu_rsp_err, e.err);
                end else begin
                    if (e.chk) check("ifu_rsp_data", ifu_rsp_data, e.data);
                    check("ifu_rsp_err", ifu_rsp_err, e.err);
                end
                $display("rsp port=%s data=%08h err=%0d", e.port ? "LSU" : "IFU",
                         e.port ? lsu_rsp_data : ifu_rsp_data, e.port ? lsu_rsp_err : ifu_rsp_err);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic lsu, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wmask);
        if (lsu) begin
            lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr;
        end
        sample();
        check("issue_ready", {lsu_req_ready, ifu_req_ready}, lsu ? 64'd2 : 64'd1);
        $display("req port=%s addr=%08h wen=%0d", lsu ? "LSU" : "IFU", addr, wen);
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        // Accepted fields may change freely afterwards.
        lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'h0; lsu_wmask = 4'h0; ifu_addr = 32'hFFFF_FFF0;
    endtask

    task automatic serve(input int rdy_dly, input int rsp_dly, input logic [31:0] ea, input logic ew,
                         input logic [31:0] ewd, input logic [3:0] ewm, input logic port,
                         input logic [31:0] rdata, input logic rerr, input logic chk);
        for (int i = 0; i <= rdy_dly; i++) begin
            mem_req_ready = (i == rdy_dly);
            sample();
            check("mem_req_valid", mem_req_valid, 64'd1);
            check("mem_addr", mem_addr, ea);
            check("mem_ctl", {mem_wen, mem_wmask}, {ew, ewm});
            if (ew) check("mem_wdata", mem_wdata, ewd);
            check("busy_no_ready", {lsu_req_ready, ifu_req_ready}, 64'd0);
            tick();
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            sample();
            check("wait_no_req", mem_req_valid, 64'd0);
            tick();
        end
        mem_rsp_valid = 1'b1; mem_rsp_data = rdata; mem_rsp_err = rerr;
        sb_q.push_back('{port: port, data: rdata, err: rerr, chk: chk});
        sample();
        check("wait_no_req", mem_req_valid, 64'd0);
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; mem_rsp_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
        repeat (3) @(posedge clk);
        #1;
        sample();
        check("rst_ctl", {mem_req_valid, mem_wen, mem_wmask, ifu_req_ready, lsu_req_ready}, 64'd0);
        check("rst_mem_data", {mem_addr, mem_wdata}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Plain IFU fetch with minimum latency.
        issue(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
        serve(0, 0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0010_0073, 1'b0, 1'b1);

        // Continuous contention: LSU first (last grant was IFU), then alternating.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
        lsu_wdata = 32'h55; lsu_wmask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("rr_grant", {lsu_req_ready, ifu_req_ready}, (k % 2 == 0) ? 64'd2 : 64'd1);
            $display("rr grant %0d -> %s", k, lsu_req_ready ? "LSU" : "IFU");
            tick();
            serve(0, 0, (k % 2 == 0) ? 32'h8000_2000 : 32'h8000_0010, 1'b0, 32'h0, 4'h0,
                  (k % 2 == 0), 32'h1000 + 32'(k), 1'b0, 1'b1);
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // Store held off for 3 cycles; response lands on the expiry cycle and wins.
        issue(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
        serve(3, 0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b0, 1'b0);

        // Load accepted but never answered: timeout 4 cycles after REQ entry.
        issue(1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0);
        mem_req_ready = 1'b1;
        sample();
        check("tmo_req_valid", mem_req_valid, 64'd1);
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("tmo_wait", mem_req_valid, 64'd0);
            tick();
        end
        sb_q.push_back('{port: 1'b1, data: 32'h0, err: 1'b1, chk: 1'b1});
        sample();
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_0BAD;
        sample();
        tick();
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;

        // Fetch never accepted: request withdrawn on expiry.
        issue(1'b0, 32'h8000_0040, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            sample();
            check("tmo_req_hold", mem_req_valid, 64'd1);
            tick();
        end
        sb_q.push_back('{port: 1'b0, data: 32'h0, err: 1'b1, chk: 1'b1});
        sample();
        check("tmo_req_drop", mem_req_valid, 64'd0);
        tick();

        // Bus error on a fetch, then an immediate LSU grant proves IDLE.
        issue(1'b0, 32'h8000_0080, 1'b0, 32'h0, 4'h0);
        serve(0, 0, 32'h8000_0080, 1'b0, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
        issue(1'b1, 32'h8000_0100, 1'b0, 32'h0, 4'h0);
        serve(0, 0, 32'h8000_0100, 1'b0, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1);

        // Reset in the middle of a request abandons it.
        issue(1'b0, 32'h8000_0200, 1'b0, 32'h0, 4'h0);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
        rst_n = 1'b0;
        sample();
        check("midrst_ctl", {mem_req_valid, ifu_req_ready, lsu_req_ready, mem_wen, mem_wmask,
                             ifu_rsp_valid, lsu_rsp_valid}, 64'd0);
        check("midrst_addr", mem_addr, 64'd0);
        tick();
        rst_n = 1'b1;
        sample();
        check("postrst_ready", {lsu_req_ready, ifu_req_ready}, 64'd1);
        tick();
        ifu_req_valid = 1'b0;
        serve(0, 0, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0000_006F, 1'b0, 1'b1);

        sample();
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
